inst_mem_fetch: RTL
===================

// Module: inst_mem_fetch
// PURPOSE
//  Parametrised instruction memory that sits between the program counter and the decoder.
//  It adds a streamed program-load port, so programs no longer need to be hard-coded.
//  Fetch uses a 1-cycle registered read with a valid strobe, and out-of-range PCs raise a fault.
//  All logic runs on one clock, Clock; the separate fetch clock is retired.
// PARAMETERS
//  DATA_W    32   instruction word width
//  PC_W      32   ProgramCounter width
//  DEPTH     128  number of words; legal PC range 0..DEPTH-1
//  NOP_WORD  0    word returned on a fetch fault
// PORTS
//  Clock           in   1          single clock; all state changes on posedge
//  Reset           in   1          synchronous, active-high
//  LoadStart       in   1          enter LOAD state; write pointer cleared to 0
//  LoadValid       in   1          LoadData is valid this cycle
//  LoadReady       out  1          block accepts a load word this cycle
//  LoadData        in   DATA_W     program word, written at the pointer
//  LoadLast        in   1          qualifies the final word of the program
//  LoadCount       out  clog2(DEPTH+1)  words written since the last LoadStart
//  Busy            out  1          1 while in LOAD
//  FetchReq        in   1          fetch request for ProgramCounter
//  ProgramCounter  in   PC_W       word address
//  Instruction     out  DATA_W     fetched word
//  InstValid       out  1          Instruction valid, 1-cycle pulse
//  Fault           out  1          fetch PC >= DEPTH, coincident with InstValid
//  ParityErr       out  1          parity mismatch on fetch (only with IMEM_PARITY_EN)
// BEHAVIOUR
//  - FSM states: RUN, LOAD. Reset forces RUN.
//  - Reset also zeroes these outputs: Instruction, InstValid, Fault, ParityErr, LoadCount, pointer.
//  - Memory contents are not cleared by Reset. Contents are undefined until loaded.
//  - RUN -> LOAD on LoadStart.
//  - LOAD -> RUN in either case:
//    - an accepted word with LoadLast=1;
//    - the accepted word that brings LoadCount to DEPTH.
//  - LOAD -> LOAD on LoadStart: the pointer and LoadCount restart at 0.
//  - LoadReady = (state==LOAD) && !LoadStart && (LoadCount<DEPTH). It is combinational from state.
//  - A word is written when LoadValid && LoadReady:
//    - mem[ptr] <= LoadData, ptr += 1, LoadCount += 1.
//    - LoadValid while LoadReady=0 writes nothing and raises no error. The word is dropped; the source must hold it.
//  - Fetch in RUN: FetchReq at cycle N gives, at cycle N+1:
//    - Instruction = mem[ProgramCounter] and InstValid = 1.
//    - Back-to-back requests give one result per cycle.
//    - Without FetchReq, InstValid = 0 and Instruction holds its last value.
//  - Range check: ProgramCounter >= DEPTH (full PC_W compare, no truncation/wrap) gives, at N+1:
//    - Instruction = NOP_WORD, InstValid = 1, Fault = 1.
//    - Fault is 0 whenever InstValid is 0.
//  - Fetch in LOAD: FetchReq is ignored; InstValid stays 0 and nothing is queued.
//    The caller must stall while Busy=1.
//  - FetchReq and LoadStart in the same RUN cycle: the fetch completes at N+1 from the old contents.
//    The FSM is in LOAD from N+1.
//  - Reset mid-load: abort to RUN. Words already written are kept; LoadCount reads 0.
//  - Reset on the same cycle as a FetchReq: that fetch is discarded and InstValid = 0 next cycle.
// CONFIGURATION
//  IMEM_PARITY_EN defined:
//   - Each word stores an extra even-parity bit, computed from LoadData on write.
//   - On fetch, a recomputed mismatch gives ParityErr=1 at N+1, with InstValid=1. Instruction is still delivered.
//   - A faulted (out-of-range) fetch never sets ParityErr.
//  IMEM_PARITY_EN undefined: no parity storage; ParityErr is tied to 0.
// TESTING
//  1. Reset, LoadStart, then 3 words with LoadLast on the third:
//     -> LoadCount=3, Busy falls after the 3rd word.
//     -> Fetch PC 0,1,2 back-to-back returns the words on consecutive cycles with InstValid=1.
//  2. Fetch PC=DEPTH and PC=32'hFFFF_FFFF:
//     -> Instruction=NOP_WORD, InstValid=1, Fault=1 one cycle later.
//  3. Load DEPTH words without LoadLast:
//     -> auto-return to RUN at LoadCount=DEPTH, LoadReady=0 afterwards.
//     -> a further LoadValid changes nothing.
//  4. LoadStart after 5 words, then 2 new words:
//     -> mem[0..1] are new, mem[2..4] are old, LoadCount=2.
//  5. FetchReq with Busy=1:
//     -> InstValid stays 0.
//     FetchReq+LoadStart together in RUN:
//     -> old mem[PC] is returned; Busy=1 on the next cycle.
//  6. Reset mid-load and mid-fetch:
//     -> all outputs 0 and RUN next cycle; previously loaded words are still fetchable.
//     With IMEM_PARITY_EN, a forced storage bit flip -> ParityErr=1 on that fetch.

Source files
------------

// File: rtl/inst_mem_fetch.sv
// ----------------------------------------------------------------------------
// inst_mem_fetch
//   Instruction memory between the program counter and the decoder.
//   - Streamed program-load port (LoadStart / LoadValid / LoadReady / LoadLast).
//   - One-cycle registered fetch with an InstValid strobe.
//   - Out-of-range PCs return NOP_WORD and raise Fault.
//   Optional feature macro: IMEM_PARITY_EN (per-word even parity, ParityErr).
//   Without IMEM_PARITY_EN there is no parity storage and ParityErr is 0.
// ----------------------------------------------------------------------------
module inst_mem_fetch #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       PC_W     = 32,
  parameter int unsigned       DEPTH    = 128,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         LoadStart,
  input  logic                         LoadValid,
  output logic                         LoadReady,
  input  logic [DATA_W-1:0]            LoadData,
  input  logic                         LoadLast,
  output logic [$clog2(DEPTH+1)-1:0]   LoadCount,
  output logic                         Busy,
  input  logic                         FetchReq,
  input  logic [PC_W-1:0]              ProgramCounter,
  output logic [DATA_W-1:0]            Instruction,
  output logic                         InstValid,
  output logic                         Fault,
  output logic                         ParityErr
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  // Architectural state
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   inst_q, inst_d;
  logic                valid_q, valid_d;
  logic                fault_q, fault_d;
  logic                perr_q, perr_d;

  // Storage (never reset; contents undefined until loaded)
  logic [DATA_W-1:0]   mem_q [DEPTH];
`ifdef IMEM_PARITY_EN
  logic                par_q [DEPTH];
`endif

  // Load-side helpers; the word count doubles as the write pointer
  logic                load_ready_c;
  logic                load_accept_c;
  logic                load_full_c;
  logic [ADDR_W-1:0]   wr_addr_c;

  // Fetch-side helpers
  logic                fetch_fire_c;
  logic                pc_in_range_c;
  logic [ADDR_W-1:0]   rd_addr_c;
  logic [DATA_W-1:0]   rd_word_c;
  logic                rd_perr_c;

  // Load handshake: ready only in LOAD, not during a restart, and while space remains
  always_comb begin
    load_ready_c  = (state_q == ST_LOAD) && !LoadStart && (cnt_q < CNT_W'(DEPTH));
    load_accept_c = LoadValid && load_ready_c;
    load_full_c   = (cnt_q == CNT_W'(DEPTH - 1));
    wr_addr_c     = ADDR_W'(cnt_q);
  end

  // Fetch address decode and range check on the full PC width
  always_comb begin
    fetch_fire_c  = (state_q == ST_RUN) && FetchReq;
    pc_in_range_c = (ProgramCounter < PC_W'(DEPTH));
    rd_addr_c     = ADDR_W'(ProgramCounter);
    rd_word_c     = mem_q[rd_addr_c];
`ifdef IMEM_PARITY_EN
    rd_perr_c     = ((^rd_word_c) != par_q[rd_addr_c]);
`else
    rd_perr_c     = 1'b0;
`endif
  end

  // Next-state and next-output logic for the RUN/LOAD controller and fetch pipe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    valid_d = 1'b0;
    fault_d = 1'b0;
    perr_d  = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (LoadStart) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (LoadStart) begin
          cnt_d = '0;
        end else if (load_accept_c) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (LoadLast || load_full_c) begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Fetch sees the contents as they stand this cycle, even if a load starts now
    if (fetch_fire_c) begin
      valid_d = 1'b1;
      if (pc_in_range_c) begin
        inst_d = rd_word_c;
        perr_d = rd_perr_c;
      end else begin
        inst_d  = NOP_WORD;
        fault_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      perr_q  <= perr_d;
    end
  end

  // Program storage write; a reset cycle never commits a word
  always_ff @(posedge Clock) begin
    if (!Reset && load_accept_c) begin
      mem_q[wr_addr_c] <= LoadData;
`ifdef IMEM_PARITY_EN
      par_q[wr_addr_c] <= ^LoadData;
`endif
    end
  end

  // Output mapping
  assign LoadReady   = load_ready_c;
  assign LoadCount   = cnt_q;
  assign Busy        = (state_q == ST_LOAD);
  assign Instruction = inst_q;
  assign InstValid   = valid_q;
  assign Fault       = fault_q;
  assign ParityErr   = perr_q;

endmodule
